// File: rtl/ones_run_tx.sv
// Serial burst transmitter: drives x high for cmd_len cycles, then low for cmd_gap cycles.
// It also predicts the output of a THRESH-deep consecutive-ones detector watching x.
module ones_run_tx #(
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             exp_detect
);

  localparam int CW = (LEN_W > GAP_W) ? LEN_W : GAP_W;
  localparam int RW = $clog2(THRESH + 1);

  typedef enum logic [1:0] {IDLE, ONES, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             done_reg, done_next;
  logic             x_reg;
  logic             det_reg;
  logic [RW-1:0]    run_reg, run_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          gap_next = cmd_gap;
          if (cmd_len != '0) begin
            state_next = ONES;
            cnt_next   = CW'(cmd_len);
          end else if (cmd_gap != '0) begin
            state_next = GAP;
            cnt_next   = CW'(cmd_gap);
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ONES: begin
        // Leave on count==1 so a loaded value of 2^W-1 sends exactly that many bits.
        if (cnt_reg == CW'(1)) begin
          if (gap_reg != '0) begin
            state_next = GAP;
            cnt_next   = CW'(gap_reg);
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      GAP: begin
        if (cnt_reg == CW'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating run counter of ones seen on x, mirroring the detector's S0..S4 walk.
  always_comb begin
    run_next = '0;
    if (x_reg) begin
      run_next = (run_reg == RW'(THRESH)) ? run_reg : run_reg + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      done_reg  <= 1'b0;
      x_reg     <= 1'b0;
      run_reg   <= '0;
      det_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      done_reg  <= done_next;
      x_reg     <= (state_next == ONES);
      run_reg   <= run_next;
      det_reg   <= (run_next == RW'(THRESH));
    end
  end

  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign x          = x_reg;
  assign done       = done_reg;
  assign exp_detect = det_reg;

endmodule

// File: tb/tb_ones_run_tx.sv
// Randomized bench for ones_run_tx: a per-cycle schedule of expected x, done and ready
// is built from each accepted command; exp_detect is predicted from the last THRESH bits.
module tb_ones_run_tx;

  localparam int THRESH = 4;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [7:0] cmd_gap;
  logic       x;
  logic       busy;
  logic       done;
  logic       exp_detect;

  ones_run_tx #(.LEN_W(8), .GAP_W(8), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_gap(cmd_gap), .x(x), .busy(busy), .done(done),
    .exp_detect(exp_detect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int gap;
    int rst_after;
    bit imm;
  } cmd_t;

  cmd_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  // Cycle c is the interval after rising edge c.
  bit   xexp[int];
  bit   rstmark[int];
  int   ready_from = 0;
  int   done_at    = -1;
  int   pend_rst   = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit x_at(int c);
    return xexp.exists(c) ? xexp[c] : 1'b0;
  endfunction

  // Detector asserts in cycle c when the THRESH cycles before it carried x=1 with no reset in between.
  function automatic bit det_at(int c);
    for (int i = 1; i <= THRESH; i++) begin
      if (c - i < 0) return 1'b0;
      if (rstmark.exists(c - i)) return 1'b0;
      if (!x_at(c - i)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset(input int e);
    ready_from = e;
    if (done_at >= e) done_at = -1;
    for (int j = e; j < e + 600; j++) if (xexp.exists(j)) xexp.delete(j);
    rstmark[e-1] = 1'b1;
  endtask

  task automatic model_accept(input int e, input int len, input int gap);
    for (int i = 0; i < len; i++) xexp[e+i] = 1'b1;
    ready_from = e + len + gap;
    done_at    = e + len + gap;
  endtask

  initial begin
    cmd_t c;
    int   idle_tail;
    bit   issue;

    // Directed scenarios first, then random ones.
    q.push_back('{4, 2, -1, 1'b1});
    q.push_back('{3, 3, -1, 1'b1});
    q.push_back('{10, 0, -1, 1'b1});
    q.push_back('{2, 1, -1, 1'b1});
    q.push_back('{0, 0, -1, 1'b1});
    q.push_back('{0, 5, -1, 1'b1});
    q.push_back('{200, 0, 50, 1'b1});
    q.push_back('{7, 3, -1, 1'b1});
    q.push_back('{255, 255, -1, 1'b0});
    q.push_back('{255, 0, -1, 1'b1});
    q.push_back('{1, 1, -1, 1'b1});
    for (int i = 0; i < 60; i++) begin
      c.len = $urandom_range(0, 12);
      c.gap = $urandom_range(0, 6);
      c.rst_after = ($urandom_range(0, 7) == 0) ? $urandom_range(1, c.len + c.gap + 2) : -1;
      c.imm = $urandom_range(0, 1);
      q.push_back(c);
    end

    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd5;
    cmd_gap   = 8'd5;
    model_reset(1);
    idle_tail = 0;

    while (idle_tail < 8 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, cyc >= ready_from});
      chk("busy", {31'd0, busy}, {31'd0, cyc < ready_from});
      chk("x", {31'd0, x}, {31'd0, x_at(cyc)});
      chk("done", {31'd0, done}, {31'd0, cyc == done_at});
      chk("exp_detect", {31'd0, exp_detect}, {31'd0, det_at(cyc)});

      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_len   = 8'($urandom);
      cmd_gap   = 8'($urandom);

      if (cyc < 3 || pend_rst == cyc) begin
        reset     = 1'b1;
        cmd_valid = 1'b1;
        pend_rst  = -1;
        model_reset(cyc + 1);
        $display("cyc %0d: reset asserted", cyc);
      end else if (cyc >= ready_from) begin
        issue = (q.size() > 0) && (q[0].imm || $urandom_range(0, 2) == 0);
        if (issue) begin
          c = q.pop_front();
          cmd_valid = 1'b1;
          cmd_len   = 8'(c.len);
          cmd_gap   = 8'(c.gap);
          model_accept(cyc + 1, c.len, c.gap);
          if (c.rst_after > 0) pend_rst = cyc + c.rst_after;
          $display("cyc %0d: cmd len=%0d gap=%0d accepted", cyc, c.len, c.gap);
        end
      end else begin
        // Held or stray requests while busy must be ignored.
        cmd_valid = $urandom_range(0, 1);
      end

      if (q.size() == 0 && cyc >= ready_from && pend_rst < 0) idle_tail++;
      else idle_tail = 0;
    end
    chk("run_complete", {31'd0, cyc < 20000}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
